// File: rtl/riscv_mpsoc_pkg.sv
// Shared types and constants for the RISC-V MPSoC regression infrastructure.
// Holds the write-back checker verdict states and the riscv-tests pass code.
package riscv_mpsoc_pkg;

    typedef enum logic [2:0] {
        CHK_IDLE    = 3'd0,
        CHK_RUN     = 3'd1,
        CHK_PASS    = 3'd2,
        CHK_FAIL    = 3'd3,
        CHK_TIMEOUT = 3'd4
    } chk_state_e;

    // riscv-tests leave gp == 1 on success; any other value encodes (test_num << 1) | 1.
    localparam int PASS_CODE = 1;

endpackage

// File: rtl/riscv_wb_select.sv
// Priority select over the snooped write-back ports: reports whether any port
// writes the watched register this cycle and which data wins.
module riscv_wb_select #(
    parameter int XLEN      = 64,
    parameter int CHANNELS  = 2,
    parameter int WATCH_REG = 3
) (
    input  logic [CHANNELS-1:0]      valid,
    input  logic [CHANNELS-1:0]      we,
    input  logic [CHANNELS*5-1:0]    addr,
    input  logic [CHANNELS*XLEN-1:0] data,
    output logic                     hit,
    output logic [XLEN-1:0]          hit_data
);

    localparam logic [4:0] WATCH_IDX = 5'(WATCH_REG);

    // Ascending scan so the highest (youngest) hitting channel overrides older ones.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (valid[i] && we[i] && (addr[5*i +: 5] == WATCH_IDX) && (addr[5*i +: 5] != 5'd0)) begin
                hit      = 1'b1;
                hit_data = data[XLEN*i +: XLEN];
            end
        end
    end

endmodule

// File: rtl/riscv_wb_checker.sv
// Regression checker: shadows one architectural register from the write-back
// ports, counts its commits and resolves a riscv-tests style verdict on halt.
module riscv_wb_checker
    import riscv_mpsoc_pkg::*;
#(
    parameter int XLEN      = 64,
    parameter int CHANNELS  = 2,
    parameter int WATCH_REG = 3,
    parameter int TIMEOUT   = 1000000,
    parameter int CNT_W     = 32
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     clr,
    input  logic [CHANNELS-1:0]      valid,
    input  logic [CHANNELS-1:0]      we,
    input  logic [CHANNELS*5-1:0]    addr,
    input  logic [CHANNELS*XLEN-1:0] data,
    input  logic                     halt,
    output logic [XLEN-1:0]          r_watch,
    output logic [CNT_W-1:0]         watch_cnt,
    output logic [CNT_W-1:0]         cycle_cnt,
    output logic                     done,
    output logic                     pass,
    output logic                     fail,
    output logic                     timeout,
    output logic [XLEN-1:0]          fail_code
);

    if ((WATCH_REG < 1) || (WATCH_REG > 31)) begin : g_bad_watch_reg
        $error("riscv_wb_checker: WATCH_REG must be in 1..31");
    end
    if ((CHANNELS < 1) || (CHANNELS > 8)) begin : g_bad_channels
        $error("riscv_wb_checker: CHANNELS must be in 1..8");
    end

    localparam bit              TO_EN   = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
    localparam logic [XLEN-1:0]  PASS_V  = XLEN'(PASS_CODE);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    chk_state_e      state;
    chk_state_e      state_nxt;
    logic            hit;
    logic [XLEN-1:0] hit_data;
    logic [XLEN-1:0] eff;
    logic            active;
    logic            to_fire;

    riscv_wb_select #(
        .XLEN      (XLEN),
        .CHANNELS  (CHANNELS),
        .WATCH_REG (WATCH_REG)
    ) u_select (
        .valid    (valid),
        .we       (we),
        .addr     (addr),
        .data     (data),
        .hit      (hit),
        .hit_data (hit_data)
    );

    // Write-first: a hit in the halt cycle decides the verdict.
    always_comb begin
        eff       = hit ? hit_data : r_watch;
        active    = (state == CHK_IDLE) || (state == CHK_RUN);
        to_fire   = TO_EN && (state == CHK_RUN) && (cycle_cnt == TO_LAST) && !halt;
        state_nxt = state;
        case (state)
            CHK_IDLE: if (|valid) state_nxt = CHK_RUN;
            CHK_RUN: begin
                if (halt)         state_nxt = (eff == PASS_V) ? CHK_PASS : CHK_FAIL;
                else if (to_fire) state_nxt = CHK_TIMEOUT;
            end
            default: state_nxt = state;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= CHK_IDLE;
            r_watch   <= '0;
            watch_cnt <= '0;
            cycle_cnt <= '0;
            fail_code <= '0;
        end else if (clr) begin
            state     <= CHK_IDLE;
            r_watch   <= '0;
            watch_cnt <= '0;
            cycle_cnt <= '0;
            fail_code <= '0;
        end else begin
            state <= state_nxt;
            if (active && hit) begin
                r_watch   <= hit_data;
                watch_cnt <= sat_inc(watch_cnt);
            end
            if (state == CHK_RUN) begin
                cycle_cnt <= sat_inc(cycle_cnt);
            end
            if ((state == CHK_RUN) && halt && (eff != PASS_V)) begin
                fail_code <= eff >> 1;
            end
        end
    end

    assign pass    = (state == CHK_PASS);
    assign timeout = (state == CHK_TIMEOUT);
    assign fail    = (state == CHK_FAIL) || (state == CHK_TIMEOUT);
    assign done    = pass || fail;

endmodule

// File: tb/tb_riscv_wb_checker.sv
// Directed self-checking bench for riscv_wb_checker (2 channels, TIMEOUT=16).
module tb_riscv_wb_checker;

    localparam int XLEN = 64;
    localparam int CH   = 2;
    localparam int CW   = 32;

    logic              clk = 1'b0;
    logic              rstn;
    logic              clr;
    logic [CH-1:0]     valid;
    logic [CH-1:0]     we;
    logic [CH*5-1:0]   addr;
    logic [CH*XLEN-1:0] data;
    logic              halt;
    logic [XLEN-1:0]   r_watch;
    logic [CW-1:0]     watch_cnt;
    logic [CW-1:0]     cycle_cnt;
    logic              done;
    logic              pass;
    logic              fail;
    logic              timeout;
    logic [XLEN-1:0]   fail_code;

    int n_checks = 0;
    int n_errors = 0;

    riscv_wb_checker #(
        .XLEN(XLEN), .CHANNELS(CH), .WATCH_REG(3), .TIMEOUT(16), .CNT_W(CW)
    ) dut (
        .clk(clk), .rstn(rstn), .clr(clr), .valid(valid), .we(we), .addr(addr),
        .data(data), .halt(halt), .r_watch(r_watch), .watch_cnt(watch_cnt),
        .cycle_cnt(cycle_cnt), .done(done), .pass(pass), .fail(fail),
        .timeout(timeout), .fail_code(fail_code)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        valid = '0; we = '0; addr = '0; data = '0; halt = 1'b0;
    endtask

    task automatic put(input int ch, input logic v, input logic w,
                       input logic [4:0] a, input logic [63:0] d);
        valid[ch] = v;
        we[ch]    = w;
        addr[5*ch +: 5]       = a;
        data[XLEN*ch +: XLEN] = d;
    endtask

    // Advance one edge, sample 1 time unit later, then release the inputs.
    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".r_watch"},   r_watch,   64'd0);
        check({tag, ".watch_cnt"}, 64'(watch_cnt), 64'd0);
        check({tag, ".cycle_cnt"}, 64'(cycle_cnt), 64'd0);
        check({tag, ".fail_code"}, fail_code, 64'd0);
        check({tag, ".flags"}, {60'd0, done, pass, fail, timeout}, 64'd0);
    endtask

    task automatic async_reset(input string tag);
        #1 rstn = 1'b0;
        #1 check_zero(tag);
        #1 rstn = 1'b1;
    endtask

    task automatic sync_clear();
        clr = 1'b1;
        step();
        clr = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rstn = 1'b0; clr = 1'b0; idle();
        #2 check_zero("reset");
        @(posedge clk); #1 rstn = 1'b1;

        // Basic pass
        put(0, 1, 1, 5'd3, 64'd5);
        step();
        check("basic.rw0", r_watch, 64'd5);
        check("basic.cnt0", 64'(watch_cnt), 64'd1);
        put(1, 1, 1, 5'd3, 64'd1);
        step();
        check("basic.rw1", r_watch, 64'd1);
        check("basic.cnt1", 64'(watch_cnt), 64'd2);
        check("basic.done_pre", 64'(done), 64'd0);
        halt = 1'b1;
        step();
        check("basic.flags", {60'd0, done, pass, fail, timeout}, 64'b1100);
        check("basic.cycles", 64'(cycle_cnt), 64'd2);
        put(0, 1, 1, 5'd3, 64'd9); halt = 1'b1;
        step();
        check("basic.sticky_rw", r_watch, 64'd1);
        check("basic.sticky_cnt", 64'(watch_cnt), 64'd2);
        check("basic.sticky_pass", 64'(pass), 64'd1);
        async_reset("rst_after_pass");

        // Fail code and stickiness
        put(0, 1, 1, 5'd3, 64'h15);
        step();
        halt = 1'b1;
        step();
        check("fail.flags", {60'd0, done, pass, fail, timeout}, 64'b1010);
        check("fail.code", fail_code, 64'hA);
        put(1, 1, 1, 5'd3, 64'd1); halt = 1'b1;
        step();
        check("fail.hold_rw", r_watch, 64'h15);
        check("fail.hold_code", fail_code, 64'hA);
        check("fail.hold_cnt", 64'(watch_cnt), 64'd1);
        check("fail.hold_flags", {60'd0, done, pass, fail, timeout}, 64'b1010);
        sync_clear();
        check_zero("clr_after_fail");

        // Collision with halt, after entering RUN via an unrelated write
        put(0, 1, 1, 5'd5, 64'h55);
        step();
        check("coll.cnt_pre", 64'(watch_cnt), 64'd0);
        put(0, 1, 1, 5'd3, 64'd7); put(1, 1, 1, 5'd3, 64'd1); halt = 1'b1;
        step();
        check("coll.rw", r_watch, 64'd1);
        check("coll.cnt", 64'(watch_cnt), 64'd1);
        check("coll.pass", 64'(pass), 64'd1);
        sync_clear();

        // Reverse-order collision without halt: channel 1 must still win
        put(0, 1, 1, 5'd3, 64'd1); put(1, 1, 1, 5'd3, 64'd7);
        step();
        check("coll2.rw", r_watch, 64'd7);
        check("coll2.cnt", 64'(watch_cnt), 64'd1);
        sync_clear();

        // Filtering
        put(0, 0, 1, 5'd3, 64'h99);
        step();
        check("filt.noval_rw", r_watch, 64'd0);
        check("filt.noval_cnt", 64'(watch_cnt), 64'd0);
        halt = 1'b1;
        step();
        check("filt.idle_halt", 64'(done), 64'd0);
        check("filt.idle_cyc", 64'(cycle_cnt), 64'd0);
        put(0, 1, 1, 5'd0, 64'h33);
        step();
        check("filt.x0_rw", r_watch, 64'd0);
        put(0, 1, 0, 5'd3, 64'h44); put(1, 1, 1, 5'd4, 64'h1);
        step();
        check("filt.we_x4_rw", r_watch, 64'd0);
        check("filt.we_x4_cnt", 64'(watch_cnt), 64'd0);
        check("filt.run_cyc", 64'(cycle_cnt), 64'd1);
        halt = 1'b1;
        step();
        check("filt.verdict", {60'd0, done, pass, fail, timeout}, 64'b1010);
        check("filt.code", fail_code, 64'd0);
        sync_clear();

        // Timeout after 16 edges in RUN
        put(0, 1, 1, 5'd5, 64'h1);
        step();
        for (int i = 0; i < 15; i++) step();
        check("to.pre_done", 64'(done), 64'd0);
        check("to.pre_cyc", 64'(cycle_cnt), 64'd15);
        step();
        check("to.flags", {60'd0, done, pass, fail, timeout}, 64'b1011);
        check("to.cyc", 64'(cycle_cnt), 64'd16);
        step();
        check("to.cyc_frozen", 64'(cycle_cnt), 64'd16);
        sync_clear();

        // Halt on the 16th edge beats the timeout
        put(0, 1, 1, 5'd3, 64'h1);
        step();
        for (int i = 0; i < 15; i++) step();
        halt = 1'b1;
        step();
        check("to_halt.flags", {60'd0, done, pass, fail, timeout}, 64'b1100);
        check("to_halt.cyc", 64'(cycle_cnt), 64'd16);
        sync_clear();

        // Reset mid-RUN, asynchronous and synchronous
        put(0, 1, 1, 5'd3, 64'h15);
        step(); step(); step();
        check("midrun.cyc", 64'(cycle_cnt), 64'd2);
        async_reset("rst_midrun");
        put(0, 1, 1, 5'd3, 64'h15);
        step(); step();
        put(1, 1, 1, 5'd3, 64'd1); halt = 1'b1; clr = 1'b1;
        step();
        clr = 1'b0;
        check_zero("clr_midrun");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/riscv_wb_checker.md
# riscv_wb_checker

Parametrised regression checker for the multi-issue RISC-V cores. It snoops CHANNELS write-back ports and keeps a shadow copy of one watched architectural register (default x3/gp). It counts committed writes to that register and runs a verdict state machine (IDLE/RUN/PASS/FAIL/TIMEOUT). The verdict follows the riscv-tests gp convention and is resolved when the core signals halt. It sits in the regression bench next to each core, and the testbench samples its outputs to end the simulation.

## Interface
- XLEN, 64, data width of the write-back ports
- CHANNELS, 2, number of write-back ports snooped (1..8)
- WATCH_REG, 3, architectural register index tracked (1..31; 0 is illegal and rejected by an elaboration-time check)
- TIMEOUT, 1000000, cycles allowed in RUN before TIMEOUT; 0 disables the timeout
- CNT_W, 32, width of the counters

- clk  in  1  core clock, all state on rising edge
- rstn  in  1  asynchronous active-low reset
- clr  in  1  synchronous clear, returns the block to reset state
- valid  in  CHANNELS  per-channel write-back valid
- we  in  CHANNELS  per-channel register-write enable
- addr  in  CHANNELS*5  per-channel destination register, channel i at [5i+4:5i]
- data  in  CHANNELS*XLEN  per-channel write data, channel i at [XLEN*i+XLEN-1:XLEN*i]
- halt  in  1  core signals end of test (ecall/tohost retire)
- r_watch  out  XLEN  shadow value of the watched register
- watch_cnt  out  CNT_W  number of committed writes to the watched register
- cycle_cnt  out  CNT_W  cycles spent in RUN
- done  out  1  verdict reached (PASS, FAIL or TIMEOUT)
- pass  out  1  state is PASS
- fail  out  1  state is FAIL or TIMEOUT
- timeout  out  1  state is TIMEOUT
- fail_code  out  XLEN  failing test number, equal to r_watch >> 1, latched on FAIL

## Operation
- A channel hits when valid[i] && we[i] && addr_i == WATCH_REG. Writes to x0 never hit.
- If several channels hit in one cycle, the highest index wins, because a higher index is the younger instruction in program order.
- watch_cnt increments by 1 per cycle with any hit, not once per hit. It saturates at all-ones.
- Shadow update, counting and timeout run only in IDLE and RUN. They freeze once done.
- States:
  - IDLE → RUN on the first cycle in which any valid[i] is set.
  - RUN → PASS on halt when the effective watched value == 1.
  - RUN → FAIL on halt when the effective watched value != 1; fail_code is latched.
  - RUN → TIMEOUT when TIMEOUT != 0 and cycle_cnt == TIMEOUT-1 with no halt that cycle.
- Effective value is write-first: if a hit and halt occur in the same cycle, the verdict uses the hitting data.
- halt in IDLE is ignored.
- If halt and the timeout occur in the same cycle, halt wins.
- PASS, FAIL and TIMEOUT are sticky until rstn or clr.
- clr has priority over every other event in its cycle.

## Timing
- Reset (rstn low, or clr): r_watch=0, watch_cnt=0, cycle_cnt=0, fail_code=0, state IDLE, so done/pass/fail/timeout=0.
- Reset is asynchronous on assertion. Deassertion is assumed synchronised by the bench.
- Reset mid-test aborts the run with no verdict output.
- Shadow latency is 1 cycle: a hit at edge N is visible on r_watch after edge N.
- Verdict latency is 1 cycle: halt sampled at edge N gives done=1 after edge N.
- cycle_cnt counts edges spent in RUN, including the edge that leaves RUN. It saturates at all-ones.
- All outputs are registered. There are no combinational paths from the inputs.

## Structure
- Add a checker state enum (IDLE, RUN, PASS, FAIL, TIMEOUT) to riscv_mpsoc_pkg.
- Add the pass code constant to riscv_mpsoc_pkg: PASS_CODE = 1.
- One sub-module, riscv_wb_select: a combinational priority select over the CHANNELS ports that produces hit and hit_data. The top level holds the counters and the FSM.

## Test plan
- Basic pass, CHANNELS=2: ch0 writes x3=5, then ch1 writes x3=1, then halt. Expect r_watch=1, watch_cnt=2, pass=1, done=1 one cycle after halt.
- Fail code: x3=0x15 written, then halt. Expect fail=1, fail_code=0xA, pass=0; the outputs hold unchanged under further writes and halts.
- Collision: ch0 writes x3=7 and ch1 writes x3=1 in the same cycle, with halt in that same cycle. Expect r_watch=1, watch_cnt=1, pass=1.
- Filtering: writes to x0, x4, and x3 with we=0 or valid=0. Expect r_watch and watch_cnt unchanged and state stays IDLE unless some valid was set.
- Timeout with TIMEOUT=16: first valid, then no halt. Expect timeout=1 and fail=1 exactly 16 edges after entering RUN, and cycle_cnt=16. With halt on the 16th edge, expect the halt verdict instead.
- Reset: assert rstn low mid-RUN and again after PASS. Expect all outputs to return to 0 immediately. Repeat with clr and expect the same after one edge.
